// File: rtl/serial_pattern_tx_if.sv
// Handshake and serial-output bundle for serial_pattern_tx.
// The master drives the request side; the slave (the transmitter) drives the stream.
interface serial_pattern_tx_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             start;
  logic [WIDTH-1:0] data;
  logic [CNT_W-1:0] reps;
  logic             abort;
  logic             x;
  logic             x_valid;
  logic             ready;
  logic             busy;
  logic             done;

  modport master (
    output start, data, reps, abort,
    input  x, x_valid, ready, busy, done
  );

  modport slave (
    input  start, data, reps, abort,
    output x, x_valid, ready, busy, done
  );
endinterface

// File: rtl/serial_pattern_tx.sv
// MSB-first serial word transmitter with repeat count, abort and done pulse.
// Produces the detector x stream; every output decodes from registered state.
module serial_pattern_tx #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  serial_pattern_tx_if.slave  bus
);
  localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] SHIFT = 2'b01;
  localparam logic [1:0] DONE  = 2'b10;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [BCW-1:0]   bcnt_q, bcnt_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    word_d  = word_q;
    bcnt_d  = bcnt_q;
    rcnt_d  = rcnt_q;
    case (state_q)
      IDLE: begin
        // abort wins over a same-cycle start
        if (bus.start && !bus.abort) begin
          sr_d    = bus.data;
          word_d  = bus.data;
          rcnt_d  = bus.reps;
          bcnt_d  = BCW'(WIDTH - 1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (bcnt_q == '0) begin
          if (rcnt_q != '0) begin
            // reload with no gap cycle between repeated words
            sr_d   = word_q;
            bcnt_d = BCW'(WIDTH - 1);
            rcnt_d = rcnt_q - 1'b1;
          end else begin
            state_d = DONE;
          end
        end else begin
          sr_d   = sr_q << 1;
          bcnt_d = bcnt_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      word_q  <= '0;
      bcnt_q  <= '0;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      word_q  <= word_d;
      bcnt_q  <= bcnt_d;
      rcnt_q  <= rcnt_d;
    end
  end

  assign bus.x       = (state_q == SHIFT) & sr_q[WIDTH-1];
  assign bus.x_valid = (state_q == SHIFT);
  assign bus.busy    = (state_q == SHIFT);
  assign bus.done    = (state_q == DONE);
  assign bus.ready   = (state_q == IDLE);
endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx: table of transfers plus abort/reset/ignored-start sequences.
module tb_serial_pattern_tx;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  serial_pattern_tx_if #(.WIDTH(8), .CNT_W(4)) bus ();

  serial_pattern_tx #(.WIDTH(8), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [3:0] reps;
    int         nbits;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Sends one transfer and checks every stream cycle, the done cycle and the ready cycle.
  // poke: pulse start with garbage data in SHIFT and in DONE, which must be ignored.
  task automatic send(input logic [7:0] d, input logic [3:0] r, input int nb, input bit poke);
    logic exp_bit;
    @(negedge clk);
    bus.start = 1'b1; bus.data = d; bus.reps = r;
    for (int k = 0; k < nb; k++) begin
      @(negedge clk);
      exp_bit = d[7 - (k % 8)];
      chk($sformatf("x[%0d]", k), {31'd0, bus.x}, {31'd0, exp_bit});
      chk($sformatf("x_valid[%0d]", k), {31'd0, bus.x_valid}, 32'd1);
      chk($sformatf("busy[%0d]", k), {31'd0, bus.busy}, 32'd1);
      chk($sformatf("done_early[%0d]", k), {31'd0, bus.done}, 32'd0);
      if (k == 0) begin
        bus.start = 1'b0; bus.data = ~d; bus.reps = 4'hF;
      end
      if (poke && k == 2) begin bus.start = 1'b1; bus.data = 8'h00; end
      if (poke && k == 3) bus.start = 1'b0;
    end
    @(negedge clk);
    chk("done_pulse", {31'd0, bus.done}, 32'd1);
    chk("done_x", {31'd0, bus.x}, 32'd0);
    chk("done_x_valid", {31'd0, bus.x_valid}, 32'd0);
    chk("done_ready", {31'd0, bus.ready}, 32'd0);
    if (poke) bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("post_ready", {31'd0, bus.ready}, 32'd1);
    chk("post_done", {31'd0, bus.done}, 32'd0);
    if (poke) begin
      @(negedge clk);
      chk("poke_no_restart", {31'd0, bus.x_valid}, 32'd0);
      chk("poke_ready", {31'd0, bus.ready}, 32'd1);
    end
  endtask

  initial begin
    vecs[0] = '{8'b0111_0110, 4'd0, 8};
    vecs[1] = '{8'hA5, 4'd2, 24};
    vecs[2] = '{8'h00, 4'd1, 16};
    vecs[3] = '{8'h81, 4'd15, 128};
    vecs[4] = '{8'hFF, 4'd0, 8};

    reset = 1'b1;
    bus.start = 1'b0; bus.data = 8'h00; bus.reps = 4'd0; bus.abort = 1'b0;
    // start held during reset must be ignored
    @(negedge clk); bus.start = 1'b1; bus.data = 8'hFF;
    @(negedge clk);
    chk("rst_x", {31'd0, bus.x}, 32'd0);
    chk("rst_x_valid", {31'd0, bus.x_valid}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_ready", {31'd0, bus.ready}, 32'd1);
    bus.start = 1'b0;
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) send(vecs[i].data, vecs[i].reps, vecs[i].nbits, 1'b0);

    // start pulsed in SHIFT and DONE is ignored
    send(8'h96, 4'd0, 8, 1'b1);

    // start together with abort in IDLE
    @(negedge clk); bus.start = 1'b1; bus.abort = 1'b1; bus.data = 8'hFF;
    @(negedge clk); bus.start = 1'b0; bus.abort = 1'b0;
    chk("sa_ready", {31'd0, bus.ready}, 32'd1);
    chk("sa_x_valid", {31'd0, bus.x_valid}, 32'd0);
    @(negedge clk);
    chk("sa_busy", {31'd0, bus.busy}, 32'd0);

    // abort after bit 3 of 8'hC3 (bits 1,1,0,0)
    @(negedge clk); bus.start = 1'b1; bus.data = 8'hC3; bus.reps = 4'd3;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      chk($sformatf("ab_x[%0d]", k), {31'd0, bus.x}, (k < 2) ? 32'd1 : 32'd0);
      chk($sformatf("ab_valid[%0d]", k), {31'd0, bus.x_valid}, 32'd1);
    end
    bus.abort = 1'b1;
    @(negedge clk); bus.abort = 1'b0;
    chk("ab_x_valid_drop", {31'd0, bus.x_valid}, 32'd0);
    chk("ab_ready", {31'd0, bus.ready}, 32'd1);
    chk("ab_no_done", {31'd0, bus.done}, 32'd0);
    @(negedge clk);
    chk("ab_no_done2", {31'd0, bus.done}, 32'd0);
    send(8'hFF, 4'd0, 8, 1'b0);

    // asynchronous reset after bit 5
    @(negedge clk); bus.start = 1'b1; bus.data = 8'h5A; bus.reps = 4'd1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      chk($sformatf("rs_x[%0d]", k), {31'd0, bus.x}, {31'd0, 8'h5A >> (7 - k) & 8'h01});
    end
    #2 reset = 1'b1;
    #1;
    chk("rs_async_x_valid", {31'd0, bus.x_valid}, 32'd0);
    chk("rs_async_busy", {31'd0, bus.busy}, 32'd0);
    chk("rs_async_x", {31'd0, bus.x}, 32'd0);
    chk("rs_async_ready", {31'd0, bus.ready}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    chk("rs_no_done", {31'd0, bus.done}, 32'd0);
    send(8'h3C, 4'd0, 8, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
